// File: rtl/sm_uart_tx.sv
// sm_uart_tx: memory-mapped, transmit-only UART.
// The CPU pushes bytes through the DATA register into a small FIFO.
// A four-state FSM serialises each byte as an 8N1 frame, LSB first, with a programmable bit period.
// irq is a registered level that is high whenever the FIFO is drained and the line has gone idle.
module sm_uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_RESET  = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bSel,
    input  logic [1:0]  bAddr,
    input  logic        bWe,
    input  logic [31:0] bWData,
    output logic [31:0] bRData,
    output logic        tx,
    output logic        irq
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_e;

    // Bus decode
    logic wrStrobe;
    logic pushReq;
    logic statusWr;
    logic divWr;

    // FIFO
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] fifoCount;
    logic             fifoEmpty;
    logic             fifoFull;
    logic             pushOk;
    logic             pop;

    // Control registers
    logic        overflow;
    logic [15:0] divReg;
    logic [15:0] periodNew;

    // Transmit engine
    txState_e    txState;
    txState_e    txStateNext;
    logic [7:0]  shiftReg;
    logic [15:0] period;
    logic [15:0] bitTimer;
    logic [2:0]  bitCnt;
    logic        bitDone;
    logic        txNext;
    logic        txReg;
    logic        irqReg;

    // Read mux helpers
    logic [31:0] statusWord;
    logic [31:0] countExt;

    assign wrStrobe = bSel & bWe;
    assign pushReq  = wrStrobe & (bAddr == ADDR_DATA);
    assign statusWr = wrStrobe & (bAddr == ADDR_STATUS);
    assign divWr    = wrStrobe & (bAddr == ADDR_DIV);

    assign fifoEmpty = (fifoCount == '0);
    assign fifoFull  = (fifoCount == FULL_COUNT);

    // A full FIFO can still take a byte when the FSM frees a slot in the same cycle.
    assign pushOk = pushReq & (~fifoFull | pop);

    // A programmed divider of zero is treated as one cycle per bit.
    assign periodNew = (divReg == 16'd0) ? 16'd1 : divReg;
    assign bitDone   = (bitTimer == 16'd0);

    assign tx  = txReg;
    assign irq = irqReg;

    // FIFO storage; needs no reset because occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoMem[wrPtr] <= bWData[7:0];
        end
    end

    // FIFO pointers and occupancy count; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({pushOk, pop})
                2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // Sticky overflow flag: set by a dropped push, cleared by writing 1 to STATUS bit 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (pushReq && !pushOk) begin
            overflow <= 1'b1;
        end else if (statusWr && bWData[3]) begin
            overflow <= 1'b0;
        end
    end

    // Bit-period divider register.
    always_ff @(posedge clk) begin
        if (rst) begin
            divReg <= 16'(DIV_RESET);
        end else if (divWr) begin
            divReg <= bWData[15:0];
        end
    end

    // Transmit FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            txState <= IDLE;
        end else begin
            txState <= txStateNext;
        end
    end

    // Next-state logic; a pop happens whenever a new frame is launched, from IDLE or straight out of STOP.
    always_comb begin
        txStateNext = txState;
        pop         = 1'b0;
        case (txState)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop         = 1'b1;
                    txStateNext = START;
                end
            end
            START: begin
                if (bitDone) begin
                    txStateNext = DATA;
                end
            end
            DATA: begin
                if (bitDone && (bitCnt == 3'd7)) begin
                    txStateNext = STOP;
                end
            end
            STOP: begin
                if (bitDone) begin
                    if (!fifoEmpty) begin
                        pop         = 1'b1;
                        txStateNext = START;
                    end else begin
                        txStateNext = IDLE;
                    end
                end
            end
            default: begin
                txStateNext = IDLE;
            end
        endcase
    end

    // Frame datapath: load byte and period on launch, then count down each bit and shift at boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            shiftReg <= 8'd0;
            period   <= 16'd1;
            bitTimer <= 16'd0;
            bitCnt   <= 3'd0;
        end else if (pop) begin
            shiftReg <= fifoMem[rdPtr];
            period   <= periodNew;
            bitTimer <= periodNew - 16'd1;
            bitCnt   <= 3'd0;
        end else if (txState != IDLE) begin
            if (bitDone) begin
                bitTimer <= period - 16'd1;
                if (txState == DATA) begin
                    shiftReg <= {1'b0, shiftReg[7:1]};
                    bitCnt   <= bitCnt + 3'd1;
                end
            end else begin
                bitTimer <= bitTimer - 16'd1;
            end
        end
    end

    // Line level for the current state, registered below so the pin never glitches.
    always_comb begin
        txNext = 1'b1;
        case (txState)
            START:   txNext = 1'b0;
            DATA:    txNext = shiftReg[0];
            default: txNext = 1'b1;
        endcase
    end

    // Registered serial output and interrupt level.
    always_ff @(posedge clk) begin
        if (rst) begin
            txReg  <= 1'b1;
            irqReg <= 1'b1;
        end else begin
            txReg  <= txNext;
            irqReg <= fifoEmpty & (txStateNext == IDLE);
        end
    end

    // STATUS word assembly: busy, full, empty, overflow and the FIFO count in bits 11:8.
    always_comb begin
        countExt        = 32'(fifoCount);
        statusWord      = 32'd0;
        statusWord[0]   = (txState != IDLE);
        statusWord[1]   = fifoFull;
        statusWord[2]   = fifoEmpty;
        statusWord[3]   = overflow;
        statusWord[11:8] = countExt[3:0];
    end

    // Zero-wait-state read mux keyed only by the word offset.
    always_comb begin
        bRData = 32'd0;
        case (bAddr)
            ADDR_STATUS: bRData = statusWord;
            ADDR_DIV:    bRData = {16'd0, divReg};
            default:     bRData = 32'd0;
        endcase
    end

    // Structural invariants: the FSM never pops an empty FIFO and occupancy never exceeds the depth.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(pop && fifoEmpty));
            assert (fifoCount <= FULL_COUNT);
        end
    end

endmodule

// File: tb/tb_sm_uart_tx.sv
// tb_sm_uart_tx: scoreboard bench for sm_uart_tx.
// Every accepted DATA write queues the frame the line should carry.
// A monitor reconstructs frames from tx sample by sample and compares them against the queue.
// Register reads are checked directly against hand-computed values.
module tb_sm_uart_tx;

    localparam int DIV_RESET = 434;

    logic        clk;
    logic        rst;
    logic        bSel;
    logic [1:0]  bAddr;
    logic        bWe;
    logic [31:0] bWData;
    logic [31:0] bRData;
    logic        tx;
    logic        irq;

    sm_uart_tx #(.FIFO_DEPTH(4), .DIV_RESET(DIV_RESET)) dut (
        .clk    (clk),
        .rst    (rst),
        .bSel   (bSel),
        .bAddr  (bAddr),
        .bWe    (bWe),
        .bWData (bWData),
        .bRData (bRData),
        .tx     (tx),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         period;
        int         expStart;
        bit         backToBack;
    } frameExp_t;

    frameExp_t sbQ[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Edge counter: after posedge k settles, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state
    bit        inFrame  = 1'b0;
    bit        skipping = 1'b0;
    bit        frameBad;
    frameExp_t cur;
    int        sampleIdx;
    int        lastEnd = -100;
    int        badIdx;
    logic      badVal;
    logic      badExp;
    int        bitPos;
    logic      expBit;

    // Monitor: samples tx on each falling edge and checks whole frames against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            inFrame  = 1'b0;
            skipping = 1'b0;
        end else if (skipping) begin
            if (tx === 1'b1) skipping = 1'b0;
        end else begin
            if (!inFrame && tx === 1'b0) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
                    skipping = 1'b1;
                end else begin
                    cur       = sbQ.pop_front();
                    inFrame   = 1'b1;
                    sampleIdx = 0;
                    frameBad  = 1'b0;
                    if (cur.expStart >= 0) begin
                        checks++;
                        if (cyc != cur.expStart) begin
                            errors++;
                            $display("[TB] FAIL start_latency 0x%02h: start at cycle %0d, required %0d",
                                     cur.data, cyc, cur.expStart);
                        end
                    end
                    if (cur.backToBack) begin
                        checks++;
                        if (cyc != lastEnd + 1) begin
                            errors++;
                            $display("[TB] FAIL frame_gap 0x%02h: start at cycle %0d, required %0d",
                                     cur.data, cyc, lastEnd + 1);
                        end
                    end
                end
            end
            if (inFrame) begin
                bitPos = sampleIdx / cur.period;
                if (bitPos == 0)      expBit = 1'b0;
                else if (bitPos == 9) expBit = 1'b1;
                else                  expBit = cur.data[bitPos-1];
                if (tx !== expBit && !frameBad) begin
                    frameBad = 1'b1;
                    badIdx   = sampleIdx;
                    badVal   = tx;
                    badExp   = expBit;
                end
                sampleIdx++;
                if (sampleIdx == 10 * cur.period) begin
                    checks++;
                    if (frameBad) begin
                        errors++;
                        $display("[TB] FAIL frame_bits 0x%02h P=%0d: sample %0d tx=%b, required %b",
                                 cur.data, cur.period, badIdx, badVal, badExp);
                    end
                    lastEnd = cyc;
                    inFrame = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Bus write held across exactly one rising edge; edgeCyc reports which edge.
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data, output int edgeCyc);
        @(negedge clk);
        bSel   = 1'b1;
        bWe    = 1'b1;
        bAddr  = addr;
        bWData = data;
        @(posedge clk);
        #1;
        edgeCyc = cyc;
        bSel    = 1'b0;
        bWe     = 1'b0;
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] val);
        @(negedge clk);
        #1;
        bSel  = 1'b1;
        bWe   = 1'b0;
        bAddr = addr;
        #1;
        val  = bRData;
        bSel = 1'b0;
    endtask

    task automatic expectFrame(input logic [7:0] data, input int period, input int expStart, input bit b2b);
        frameExp_t f;
        f.data       = data;
        f.period     = period;
        f.expStart   = expStart;
        f.backToBack = b2b;
        sbQ.push_back(f);
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n = 0;
        while ((sbQ.size() != 0 || inFrame) && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sbQ.size() != 0 || inFrame) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: %0d frames pending after %0d cycles, required 0", name,
                     sbQ.size() + (inFrame ? 1 : 0), budget);
            sbQ.delete();
        end
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int          e;
        int          e0;
        logic [31:0] v;
        logic [7:0]  bytes5 [5];
        bytes5[0] = 8'hA5;
        bytes5[1] = 8'h3C;
        bytes5[2] = 8'hFF;
        bytes5[3] = 8'h00;
        bytes5[4] = 8'h81;

        rst    = 1'b1;
        bSel   = 1'b0;
        bWe    = 1'b0;
        bAddr  = 2'd0;
        bWData = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        // Reset state
        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_irq", {31'd0, irq}, 32'd1);
        readReg(2'd1, v); checkOutput("reset_status", v, 32'h0000_0004);
        readReg(2'd2, v); checkOutput("reset_div", v, 32'd434);
        readReg(2'd0, v); checkOutput("data_reads_zero", v, 32'd0);
        applyStimulus(2'd3, 32'hFFFF_FFFF, e);
        readReg(2'd3, v); checkOutput("reg3_reads_zero", v, 32'd0);
        applyStimulus(2'd2, 32'hABCD_0004, e);
        readReg(2'd2, v); checkOutput("div_readback", v, 32'd4);

        // Single frame 0x55 at P=4
        applyStimulus(2'd0, 32'h0000_0055, e);
        expectFrame(8'h55, 4, e + 2, 1'b0);
        readReg(2'd1, v); checkOutput("status_after_push", v, 32'h0000_0100);
        readReg(2'd1, v); checkOutput("status_start", v, 32'h0000_0005);
        checkOutput("irq_low_busy", {31'd0, irq}, 32'd0);
        waitIdle(200, "single");
        checkOutput("irq_after_frame", {31'd0, irq}, 32'd1);
        readReg(2'd1, v); checkOutput("status_after_frame", v, 32'h0000_0004);

        // Five contiguous frames
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'd0, {24'd0, bytes5[i]}, e);
            if (i == 0) begin
                e0 = e;
                expectFrame(bytes5[i], 4, e0 + 2, 1'b0);
            end else begin
                expectFrame(bytes5[i], 4, -1, 1'b1);
            end
        end
        readReg(2'd1, v); checkOutput("status_full_no_ovf", v, 32'h0000_0403);
        waitIdle(400, "burst5");
        readReg(2'd1, v); checkOutput("status_after_burst", v, 32'h0000_0004);

        // Overflow: six pushes, exactly one dropped
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'd0, 32'h11 + i, e);
            if (i == 0) begin
                e0 = e;
                expectFrame(8'h11, 4, e0 + 2, 1'b0);
            end else if (i < 5) begin
                expectFrame(8'(8'h11 + i), 4, -1, 1'b1);
            end
        end
        readReg(2'd1, v); checkOutput("status_overflow", v, 32'h0000_040B);
        applyStimulus(2'd1, 32'h0000_0008, e);
        readReg(2'd1, v); checkOutput("status_ovf_cleared", v, 32'h0000_0403);
        waitIdle(400, "overflow");
        readReg(2'd1, v); checkOutput("status_after_ovf", v, 32'h0000_0004);

        // DIV change mid-frame only affects the next frame
        applyStimulus(2'd0, 32'h0000_00C3, e);
        expectFrame(8'hC3, 4, e + 2, 1'b0);
        applyStimulus(2'd0, 32'h0000_005A, e);
        expectFrame(8'h5A, 8, -1, 1'b1);
        repeat (10) @(negedge clk);
        applyStimulus(2'd2, 32'd8, e);
        readReg(2'd2, v); checkOutput("div_eight", v, 32'd8);
        waitIdle(400, "divchange");

        // DIV=0 behaves as one cycle per bit
        applyStimulus(2'd2, 32'd0, e);
        readReg(2'd2, v); checkOutput("div_zero", v, 32'd0);
        applyStimulus(2'd0, 32'h0000_0096, e);
        expectFrame(8'h96, 1, e + 2, 1'b0);
        applyStimulus(2'd0, 32'h0000_0069, e);
        expectFrame(8'h69, 1, -1, 1'b1);
        waitIdle(100, "divzero");

        // Reset in the middle of a data bit with bytes queued
        applyStimulus(2'd2, 32'd4, e);
        applyStimulus(2'd0, 32'h0000_00DE, e0);
        expectFrame(8'hDE, 4, e0 + 2, 1'b0);
        applyStimulus(2'd0, 32'h0000_00AD, e);
        expectFrame(8'hAD, 4, -1, 1'b1);
        applyStimulus(2'd0, 32'h0000_00BE, e);
        expectFrame(8'hBE, 4, -1, 1'b1);
        while (cyc < e0 + 7) @(negedge clk);
        #1;
        checkOutput("pre_reset_tx_bit0", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        sbQ.delete();
        @(posedge clk);
        #1;
        checkOutput("reset_abort_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        readReg(2'd1, v); checkOutput("reset_abort_status", v, 32'h0000_0004);
        readReg(2'd2, v); checkOutput("reset_abort_div", v, 32'd434);
        checkOutput("reset_abort_irq", {31'd0, irq}, 32'd1);
        repeat (100) @(negedge clk);
        #1;
        checkOutput("post_reset_idle_tx", {31'd0, tx}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
